gate_logic_pipe: RTL and testbench
==================================

# gate_logic_pipe

Parametrised, pipelined bitwise logic unit that generalises the lab's fixed 2-bit single-function gate modules into one WIDTH-bit block. The block applies an opcode-selected NOT/AND/OR/NAND/NOR/XOR/XNOR operation to two operands. It moves operands and results through a two-stage valid/ready pipeline, so it can sit between a stimulus source and a result sink that may stall. It also produces zero and parity flags, an illegal-opcode error, and a count of completed transactions.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_WIDTH, 16, width of completed-transaction counter
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts beat this cycle
- in_a  input  WIDTH  operand A (sole operand for NOT)
- in_b  input  WIDTH  operand B (ignored for NOT)
- in_op  input  3  opcode, gate_pkg::op_e
- out_valid  output  1  result beat present
- out_ready  input  1  sink accepts result this cycle
- out_y  output  WIDTH  result
- out_zero  output  1  out_y == 0
- out_parity  output  1  XOR-reduction of out_y
- out_err  output  1  opcode was illegal
- txn_count  output  CNT_WIDTH  results consumed since reset

## Operation
- Opcodes:
  - 0 NOT: y=~a
  - 1 AND
  - 2 OR
  - 3 NAND
  - 4 NOR
  - 5 XOR
  - 6 XNOR
  - 7 illegal: y=0, err=1
- All operations are bitwise over the full WIDTH. There is no carry and no width growth.
- Stage 1 (S1): registers a, b, op and s1_valid on an input handshake (in_valid && in_ready).
- Stage 2 (S2): registers y, zero, parity, err and s2_valid, computed from the S1 contents.
  - out_* are driven directly from S2 registers.
- Flow control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
- S2 loads when s2_adv is high. It takes s1_valid, and takes the S1 data only if s1_valid.
- S1 loads when s1_adv is high. It takes in_valid, and takes the input data only if in_valid.
- A stalled stage holds all its registers unchanged.
- out_y, out_zero, out_parity and out_err hold stable while out_valid && !out_ready.
- txn_count increments on each output handshake (out_valid && out_ready). It wraps from 2^CNT_WIDTH−1 to 0.
- Reset values:
  - s1_valid = 0, s2_valid = 0, out_valid = 0
  - out_y = 0, out_zero = 0, out_parity = 0, out_err = 0
  - txn_count = 0
- in_ready is 1 in the cycle after reset releases.
- Reset mid-operation discards all in-flight beats. No partial result appears.
- If an input handshake and an output handshake occur in the same cycle, both take effect and the pipeline advances.

## Timing
- Latency is 2 cycles. A beat accepted at edge N is presented on out_* after edge N+1 and is consumable at edge N+2.
- Throughput is 1 beat/cycle while out_ready is held high.
- Capacity is 2 beats. With out_ready low, in_ready drops once both stages are valid.
- The in_ready path is combinational from out_ready (two gate levels). No combinational path runs from in_* to out_*.
- When out_ready rises after a stall, in_ready rises in the same cycle and both beats drain in order.
- While rst is high, handshakes are ignored. in_ready is don't-care.

## Structure
- Package gate_pkg holds:
  - typedef enum logic [2:0] op_e {OP_NOT, OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_ILLEGAL}
  - localparam OP_W = 3
- Sub-module gate_logic_comb: parameter WIDTH; inputs a, b, op; outputs y, err.
  - Purely combinational, using a case on op_e.
  - Instantiated between S1 and S2.
- zero and parity are computed in gate_logic_pipe from the gate_logic_comb y before S2 registration.

## Test plan
All cases use WIDTH=8 and out_ready=1 unless stated.
- Reset check: hold rst 3 cycles with in_valid=1.
  - out_valid=0, out_y=0, txn_count=0.
  - in_ready=1 one cycle after release.
- Opcode sweep: a=8'hA5, b=8'h0F, op 0..7, one beat per cycle.
  - Outputs, 2 cycles after each accept, in order: 5A, 05, AF, FA, 50, AA, 55, 00.
  - Only the last beat has err=1.
  - Parity 0 on every beat.
  - The AND beat (05) has zero=0.
  - The op 7 beat has zero=1.
- Back-pressure: out_ready=0, send 3 beats AND(FF,01), AND(FF,02), AND(FF,04).
  - in_ready falls after 2 accepts.
  - out_y holds 01 stable.
  - On out_ready=1, outputs 01, 02, 04 in order.
  - txn_count ends at 3.
- Simultaneous handshake: stream 10 XOR beats a=i, b=8'hFF with out_ready toggling every cycle.
  - No loss or duplication; outputs are ~i in order.
  - txn_count=10.
- Mid-flight reset: accept 2 beats, assert rst for one cycle.
  - No out_valid follows for either beat.
  - The next accepted beat appears after the normal 2-cycle latency.
- Counter wrap: CNT_WIDTH=4, 17 beats.
  - txn_count reads 1 after the last handshake.

Source files
------------

// File: rtl/gate_pkg.sv
// gate_pkg: opcode encoding shared by the logic pipe and its combinational core
package gate_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_NOT, OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_ILLEGAL
    } op_e;
endpackage

// File: rtl/gate_logic_comb.sv
// gate_logic_comb: opcode-selected bitwise gate, purely combinational
module gate_logic_comb
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic             err
);
    always_comb begin
        y = '0;
        err = 1'b0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/gate_logic_pipe.sv
// gate_logic_pipe: two-stage valid/ready bitwise logic unit with zero/parity/error
// flags and a wrapping count of consumed results.
module gate_logic_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  op_e                  in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_y,
    output logic                 out_zero,
    output logic                 out_parity,
    output logic                 out_err,
    output logic [CNT_WIDTH-1:0] txn_count
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic [WIDTH-1:0] y;
    logic             err;
    logic             s1_adv;
    logic             s2_adv;

    // Ready ripples backwards: a stage may load if it is empty or draining.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    gate_logic_comb #(.WIDTH(WIDTH)) u_comb (
        .a   (s1_a),
        .b   (s1_b),
        .op  (s1_op),
        .y   (y),
        .err (err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_NOT;
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
            out_err    <= 1'b0;
            txn_count  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a  <= in_a;
                    s1_b  <= in_b;
                    s1_op <= in_op;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_y      <= y;
                    out_zero   <= ~|y;
                    out_parity <= ^y;
                    out_err    <= err;
                end
            end
            if (out_valid && out_ready)
                txn_count <= txn_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_gate_logic_pipe.sv
// tb_gate_logic_pipe: table-driven opcode sweep plus scoreboard-checked stall,
// reset and counter-wrap sequences.
module tb_gate_logic_pipe;
    import gate_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic       err;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] y;
        logic       err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    op_e         in_op = OP_NOT;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_y;
    logic        out_zero;
    logic        out_parity;
    logic        out_err;
    logic [15:0] txn_count;

    logic        in_ready4, out_valid4, out_zero4, out_parity4, out_err4;
    logic [7:0]  out_y4;
    logic [3:0]  txn_count4;

    logic [7:0]  cur_ey = '0;
    logic        cur_err = 1'b0;
    logic        toggle_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [7:0]  held_y = '0;
    exp_t        sb[$];
    exp_t        e_in, e_out;
    vec_t        tbl[8];
    int          n_cmp = 0;
    int          n_bad = 0;

    gate_logic_pipe #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
        .out_parity(out_parity), .out_err(out_err), .txn_count(txn_count)
    );

    // Narrow-counter twin sharing the stimulus, used for the wrap check.
    gate_logic_pipe #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
        .out_ready(out_ready), .out_y(out_y4), .out_zero(out_zero4),
        .out_parity(out_parity4), .out_err(out_err4), .txn_count(txn_count4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: push on input handshake, pop and compare on output handshake.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("hold_y", out_y, held_y);
            if (in_valid && in_ready) begin
                e_in.y = cur_ey;
                e_in.err = cur_err;
                sb.push_back(e_in);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out: got y=%0h with empty scoreboard, expected no beat", out_y);
                end else begin
                    e_out = sb.pop_front();
                    chk("out_y", out_y, e_out.y);
                    chk("out_err", out_err, e_out.err);
                    chk("out_zero", out_zero, e_out.y == 8'h00);
                    chk("out_parity", out_parity, ^e_out.y);
                end
            end
            stall_prev = out_valid && !out_ready;
            held_y = out_y;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (toggle_en) out_ready = ~out_ready;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] ey, input logic ee);
        int t = 0;
        logic acc;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op_e'(op);
        cur_ey = ey;
        cur_err = ee;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            if (++t > 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) break;
            if (++t > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain_timeout: %0d beats left, expected 0", sb.size());
                break;
            end
        end
    endtask

    task automatic do_reset(input int n, input logic v);
        rst = 1'b1;
        in_valid = v;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_txn_count", txn_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{3'd0, 8'h5A, 1'b0};
        tbl[1] = '{3'd1, 8'h05, 1'b0};
        tbl[2] = '{3'd2, 8'hAF, 1'b0};
        tbl[3] = '{3'd3, 8'hFA, 1'b0};
        tbl[4] = '{3'd4, 8'h50, 1'b0};
        tbl[5] = '{3'd5, 8'hAA, 1'b0};
        tbl[6] = '{3'd6, 8'h55, 1'b0};
        tbl[7] = '{3'd7, 8'h00, 1'b1};

        do_reset(3, 1'b1);

        for (int i = 0; i < 8; i++)
            send(8'hA5, 8'h0F, tbl[i].op, tbl[i].y, tbl[i].err);
        drain();
        chk("sweep_txn_count", txn_count, 8);

        do_reset(1, 1'b0);
        out_ready = 1'b0;
        send(8'hFF, 8'h01, 3'd1, 8'h01, 1'b0);
        send(8'hFF, 8'h02, 3'd1, 8'h02, 1'b0);
        in_valid = 1'b1;
        in_a = 8'hFF;
        in_b = 8'h04;
        in_op = OP_AND;
        cur_ey = 8'h04;
        cur_err = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_y", out_y, 8'h01);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        chk("bp_txn_count", txn_count, 3);

        do_reset(1, 1'b0);
        toggle_en = 1'b1;
        for (int i = 0; i < 10; i++)
            send(8'(i), 8'hFF, 3'd5, ~8'(i), 1'b0);
        drain();
        toggle_en = 1'b0;
        out_ready = 1'b1;
        chk("sim_txn_count", txn_count, 10);

        do_reset(1, 1'b0);
        out_ready = 1'b0;
        send(8'h3C, 8'h0F, 3'd2, 8'h3F, 1'b0);
        send(8'h3C, 8'h0F, 3'd1, 8'h0C, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(8'hC3, 8'hFF, 3'd6, 8'hC3, 1'b0);
        @(negedge clk);
        chk("lat_edge1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_edge2_valid", out_valid, 1);
        chk("lat_edge2_y", out_y, 8'hC3);
        drain();
        chk("mid_rst_txn_count", txn_count, 1);

        do_reset(1, 1'b0);
        for (int i = 0; i < 17; i++)
            send(8'(i), 8'hFF, 3'd1, 8'(i), 1'b0);
        drain();
        chk("wrap_txn_count16", txn_count, 17);
        chk("wrap_txn_count4", txn_count4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
